// File: rtl/count_bcd_display.sv
// ============================================================================
// count_bcd_display: binary-to-BCD converter with five 7-segment outputs.
// Optional leading-zero blanking with macro COUNT_BCD_DISPLAY_BLANK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module count_bcd_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      count,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4
);

  localparam int              ITER_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      bin_sr_q;
  logic [4*DIGITS-1:0]   acc_q;
  logic [4*DIGITS-1:0]   acc_adj_d;
  logic [ITER_W-1:0]     iter_q;
  logic                  busy_q;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [6:0]            seg_w [DIGITS];

  // Add-3 correction applied to each nibble on its own before the shift.
  always_comb begin
    acc_adj_d = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj_d[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // busy stays high through the done cycle, so it spans WIDTH+2 cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      bin_sr_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            bin_sr_q <= count;
            acc_q    <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q    <= {acc_adj_d[4*DIGITS-2:0], bin_sr_q[WIDTH-1]};
          bin_sr_q <= {bin_sr_q[WIDTH-2:0], 1'b0};
          iter_q   <= iter_q + ITER_W'(1);
          if (iter_q == LAST_ITER) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_q   <= acc_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
`ifdef COUNT_BCD_DISPLAY_BLANK_EN
    if (k == 0) begin : g_lsd
      assign seg_w[k] = seg7(bcd_q[3:0]);
    end else begin : g_blank
      // Blank this digit when it and every more-significant digit are zero.
      assign seg_w[k] = (bcd_q[4*DIGITS-1:4*k] == '0) ? 7'h7F
                                                      : seg7(bcd_q[4*k +: 4]);
    end
`else
    assign seg_w[k] = seg7(bcd_q[4*k +: 4]);
`endif
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign hex0 = seg_w[0];
  assign hex1 = seg_w[1];
  assign hex2 = seg_w[2];
  assign hex3 = seg_w[3];
  assign hex4 = seg_w[4];

endmodule

`default_nettype wire
